// File: rtl/updown_dir_ctrl.sv
// Direction controller for the 4-bit up/down counter: debounces up/down/hold buttons into status/clr/cnt_en.
// Define DIR_CHG_CNT_EN to build the saturating direction-change tally on o_chg_cnt.
module updown_dir_ctrl #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_hold,
  output logic       o_status,
  output logic       o_clr,
  output logic       o_cnt_en,
  output logic       o_err,
  output logic [7:0] o_chg_cnt
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    UP        = 2'b00,
    DOWN      = 2'b01,
    HOLD_UP   = 2'b10,
    HOLD_DOWN = 2'b11
  } state_t;

  // Bit 0 = up, bit 1 = down, bit 2 = hold throughout the button pipeline.
  logic [2:0] w_btn;
  logic [2:0] r_s1;
  logic [2:0] r_s2;
  logic [2:0] r_deb;
  logic [2:0] r_deb_d;
  logic [2:0] r_evt;
  logic [7:0] r_stab [3];

  assign w_btn = {i_btn_hold, i_btn_down, i_btn_up};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_evt   <= '0;
      for (int i = 0; i < 3; i++) r_stab[i] <= '0;
    end else begin
      r_s1    <= w_btn;
      r_s2    <= r_s1;
      r_deb_d <= r_deb;
      r_evt   <= r_deb & ~r_deb_d;
      // The debounced level flips on the DEB_CYCLES-th consecutive differing sample.
      for (int i = 0; i < 3; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_stab[i] <= '0;
        end else if (r_stab[i] == DEB_LAST) begin
          r_deb[i]  <= r_s2[i];
          r_stab[i] <= '0;
        end else begin
          r_stab[i] <= r_stab[i] + 8'd1;
        end
      end
    end
  end

  state_t r_state;
  state_t w_next;
  logic   w_conflict;
  logic   w_down_dir;
  logic   w_chg;

  assign w_conflict = r_evt[0] & r_evt[1];
  assign w_down_dir = (r_state == DOWN) || (r_state == HOLD_DOWN);
  assign w_chg      = !w_conflict && (w_down_dir ? r_evt[0] : r_evt[1]);

  // A direction change and a hold toggle in the same cycle both take effect.
  always_comb begin
    w_next = r_state;
    case (r_state)
      UP:        w_next = w_chg ? (r_evt[2] ? HOLD_DOWN : DOWN)    : (r_evt[2] ? HOLD_UP   : UP);
      DOWN:      w_next = w_chg ? (r_evt[2] ? HOLD_UP   : UP)      : (r_evt[2] ? HOLD_DOWN : DOWN);
      HOLD_UP:   w_next = w_chg ? (r_evt[2] ? DOWN      : HOLD_DOWN) : (r_evt[2] ? UP      : HOLD_UP);
      HOLD_DOWN: w_next = w_chg ? (r_evt[2] ? UP        : HOLD_UP) : (r_evt[2] ? DOWN      : HOLD_DOWN);
      default:   w_next = UP;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= UP;
      o_status <= 1'b0;
      o_clr    <= 1'b1;
      o_cnt_en <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      o_status <= (w_next == DOWN) || (w_next == HOLD_DOWN);
      o_cnt_en <= (w_next == UP) || (w_next == DOWN);
      o_clr    <= w_chg;
      o_err    <= w_conflict;
    end
  end

`ifdef DIR_CHG_CNT_EN
  logic [7:0] r_chg_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chg_cnt <= '0;
    end else if (w_chg && (r_chg_cnt != 8'hFF)) begin
      r_chg_cnt <= r_chg_cnt + 8'd1;
    end
  end

  assign o_chg_cnt = r_chg_cnt;
`else
  assign o_chg_cnt = 8'd0;
`endif

endmodule
